// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// EX-stage mispredict/redirect generation and saturating branch statistics.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);
    localparam int          TAG_W    = XLEN - IDX_W - 2;
    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [31:0]      r_statBranches;
    logic [31:0]      r_statMispredicts;

    logic [IDX_W-1:0] w_ifIdx;
    logic [IDX_W-1:0] w_updIdx;
    logic [TAG_W-1:0] w_ifTag;
    logic [TAG_W-1:0] w_updTag;
    logic             w_ifHit;
    logic             w_updHit;
    logic             w_mispredict;
    logic [1:0]       w_unusedPcBits;

    // Instructions are word aligned, so the byte offset never selects an entry.
    assign w_unusedPcBits = if_pc[1:0];

    assign w_ifIdx  = if_pc[IDX_W+1:2];
    assign w_ifTag  = if_pc[XLEN-1:IDX_W+2];
    assign w_updIdx = upd_pc[IDX_W+1:2];
    assign w_updTag = upd_pc[XLEN-1:IDX_W+2];

    assign w_ifHit  = r_valid[w_ifIdx] && (r_tag[w_ifIdx] == w_ifTag);
    assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);

    assign pred_taken  = w_ifHit && r_ctr[w_ifIdx][1];
    assign pred_target = pred_taken ? r_target[w_ifIdx] : '0;

    assign w_mispredict = upd_valid &&
                          ((upd_taken != upd_pred_taken) ||
                           (upd_taken && (upd_target != upd_pred_target)));
    assign mispredict   = w_mispredict;
    assign redirect_pc  = !w_mispredict ? '0 :
                          upd_taken     ? upd_target :
                                          upd_pc + XLEN'(4);

    // Tags and targets carry no reset; an entry is only trusted once valid is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (w_updHit) begin
                if (upd_taken) begin
                    if (r_ctr[w_updIdx] != 2'b11) begin
                        r_ctr[w_updIdx] <= r_ctr[w_updIdx] + 2'd1;
                    end
                    r_target[w_updIdx] <= upd_target;
                end else if (r_ctr[w_updIdx] != 2'b00) begin
                    r_ctr[w_updIdx] <= r_ctr[w_updIdx] - 2'd1;
                end
            end else if (upd_taken) begin
                r_valid[w_updIdx]  <= 1'b1;
                r_tag[w_updIdx]    <= w_updTag;
                r_target[w_updIdx] <= upd_target;
                r_ctr[w_updIdx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_statBranches    <= '0;
            r_statMispredicts <= '0;
        end else begin
            if (upd_valid && (r_statBranches != STAT_MAX)) begin
                r_statBranches <= r_statBranches + 32'd1;
            end
            if (w_mispredict && (r_statMispredicts != STAT_MAX)) begin
                r_statMispredicts <= r_statMispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_statBranches;
    assign stat_mispredicts = r_statMispredicts;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic compared against an arithmetic reference model.
module tb_branch_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam longint STAT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] if_pc = '0;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid = 1'b0;
    logic [XLEN-1:0] upd_pc = '0;
    logic            upd_taken = 1'b0;
    logic [XLEN-1:0] upd_target = '0;
    logic            upd_pred_taken = 1'b0;
    logic [XLEN-1:0] upd_pred_target = '0;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: one slot per index, holding the full upper PC bits as tag.
    bit          mValid  [ENTRIES];
    logic [31:0] mTag    [ENTRIES];
    logic [31:0] mTarget [ENTRIES];
    int          mCtr    [ENTRIES];
    longint      mBranches;
    longint      mMispredicts;

    logic [31:0] pcPool     [8] = '{32'h100, 32'h140, 32'h180, 32'h1C0,
                                    32'h104, 32'h2000, 32'h2040, 32'h10C};
    logic [31:0] targetPool [4] = '{32'h200, 32'h300, 32'h400, 32'h8000};

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    function automatic int modelIdx(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'(ENTRIES));
    endfunction

    function automatic logic [31:0] modelTag(input logic [31:0] pc);
        return pc / (32'd4 * 32'(ENTRIES));
    endfunction

    function automatic bit modelHit(input logic [31:0] pc);
        return mValid[modelIdx(pc)] && (mTag[modelIdx(pc)] == modelTag(pc));
    endfunction

    function automatic bit modelPredTaken(input logic [31:0] pc);
        return modelHit(pc) && (mCtr[modelIdx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] modelPredTarget(input logic [31:0] pc);
        return modelPredTaken(pc) ? mTarget[modelIdx(pc)] : 32'd0;
    endfunction

    function automatic bit modelMispredict();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    function automatic logic [31:0] modelRedirect();
        if (!modelMispredict()) return 32'd0;
        return upd_taken ? upd_target : upd_pc + 32'd4;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 1'b0;
            mCtr[i]   = 1;
        end
        mBranches    = 0;
        mMispredicts = 0;
    endtask

    task automatic modelUpdate();
        int idx;
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (!upd_valid) return;
        idx = modelIdx(upd_pc);
        if (modelMispredict() && mMispredicts < STAT_MAX) mMispredicts++;
        if (mBranches < STAT_MAX) mBranches++;
        if (modelHit(upd_pc)) begin
            if (upd_taken) begin
                mCtr[idx]    = (mCtr[idx] + 1 > 3) ? 3 : mCtr[idx] + 1;
                mTarget[idx] = upd_target;
            end else begin
                mCtr[idx] = (mCtr[idx] - 1 < 0) ? 0 : mCtr[idx] - 1;
            end
        end else if (upd_taken) begin
            mValid[idx]  = 1'b1;
            mTag[idx]    = modelTag(upd_pc);
            mTarget[idx] = upd_target;
            mCtr[idx]    = 2;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic checkAgainstModel();
        checkOutput("pred_taken", 32'(pred_taken), 32'(modelPredTaken(if_pc)));
        checkOutput("pred_target", pred_target, modelPredTarget(if_pc));
        checkOutput("mispredict", 32'(mispredict), 32'(modelMispredict()));
        checkOutput("redirect_pc", redirect_pc, modelRedirect());
        checkOutput("stat_branches", stat_branches, 32'(mBranches));
        checkOutput("stat_mispredicts", stat_mispredicts, 32'(mMispredicts));
    endtask

    task automatic driveInputs(input logic [31:0] ifPc, input logic valid, input logic [31:0] pc,
                               input logic taken, input logic [31:0] target,
                               input logic predTaken, input logic [31:0] predTarget);
        if_pc           = ifPc;
        upd_valid       = valid;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = target;
        upd_pred_taken  = predTaken;
        upd_pred_target = predTarget;
    endtask

    task automatic stepClock();
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] ifPc, input logic valid, input logic [31:0] pc,
                                 input logic taken, input logic [31:0] target,
                                 input logic predTaken, input logic [31:0] predTarget);
        driveInputs(ifPc, valid, pc, taken, target, predTaken, predTarget);
        #1;
        checkAgainstModel();
        stepClock();
    endtask

    // A pending allocating update during reset must be dropped.
    task automatic resetDut();
        rst_n = 1'b0;
        driveInputs(32'h100, 1'b1, 32'h100, 1'b1, 32'h900, 1'b0, 32'h0);
        stepClock();
        stepClock();
        rst_n = 1'b1;
        driveInputs(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] rPc;
        logic [31:0] rIf;
        logic [31:0] rTgt;
        logic        rTaken;
        logic        rPredTaken;
        logic [31:0] rPredTarget;

        modelReset();
        @(posedge clk);
        #1;
        resetDut();

        // Clean state after reset
        driveInputs(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("rst_pred_taken", 32'(pred_taken), 32'd0);
        checkOutput("rst_pred_target", pred_target, 32'd0);
        checkOutput("rst_stat_branches", stat_branches, 32'd0);
        checkOutput("rst_stat_mispredicts", stat_mispredicts, 32'd0);
        checkAgainstModel();
        stepClock();

        // First taken resolution allocates with ctr=2
        driveInputs(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        #1;
        checkOutput("alloc_mispredict", 32'(mispredict), 32'd1);
        checkOutput("alloc_redirect", redirect_pc, 32'h200);
        checkOutput("alloc_same_cycle_pred", 32'(pred_taken), 32'd0);
        checkAgainstModel();
        stepClock();
        driveInputs(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("alloc_next_pred", 32'(pred_taken), 32'd1);
        checkOutput("alloc_next_target", pred_target, 32'h200);
        stepClock();

        // Two not-taken resolutions walk the counter down to 0
        driveInputs(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        #1;
        checkOutput("nt1_mispredict", 32'(mispredict), 32'd1);
        checkOutput("nt1_redirect", redirect_pc, 32'h104);
        checkAgainstModel();
        stepClock();
        driveInputs(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("nt2_mispredict", 32'(mispredict), 32'd0);
        checkOutput("nt2_redirect", redirect_pc, 32'd0);
        stepClock();
        driveInputs(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("nt_final_pred", 32'(pred_taken), 32'd0);
        checkAgainstModel();
        stepClock();

        // Same-cycle lookup sees pre-update contents, then aliasing replacement
        resetDut();
        driveInputs(32'h140, 1'b1, 32'h140, 1'b1, 32'h500, 1'b0, 32'h0);
        #1;
        checkOutput("bypass_same_cycle", 32'(pred_taken), 32'd0);
        stepClock();
        driveInputs(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("bypass_next_cycle", 32'(pred_taken), 32'd1);
        checkOutput("bypass_next_target", pred_target, 32'h500);
        stepClock();
        applyStimulus(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        applyStimulus(32'h100, 1'b1, 32'h100 + 32'(4 * ENTRIES), 1'b1, 32'h600, 1'b0, 32'h0);
        driveInputs(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("alias_old_pred", 32'(pred_taken), 32'd0);
        stepClock();
        driveInputs(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("alias_new_target", pred_target, 32'h600);
        stepClock();

        // Wrong target with right direction, and counter saturation
        force dut.r_statBranches = 32'hFFFF_FFFE;
        force dut.r_statMispredicts = 32'hFFFF_FFFE;
        #1;
        release dut.r_statBranches;
        release dut.r_statMispredicts;
        mBranches    = 64'h0000_0000_FFFF_FFFE;
        mMispredicts = 64'h0000_0000_FFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            driveInputs(32'h180, 1'b1, 32'h180, 1'b1, 32'h200, 1'b1, 32'h300);
            #1;
            checkOutput("tgt_mispredict", 32'(mispredict), 32'd1);
            checkOutput("tgt_redirect", redirect_pc, 32'h200);
            checkAgainstModel();
            stepClock();
        end
        driveInputs(32'h180, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("sat_branches", stat_branches, 32'hFFFF_FFFF);
        checkOutput("sat_mispredicts", stat_mispredicts, 32'hFFFF_FFFF);
        stepClock();

        // Randomized traffic over a small aliasing PC pool
        resetDut();
        for (int n = 0; n < 600; n++) begin
            rIf    = pcPool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            rPc    = pcPool[$urandom_range(0, 7)];
            rTaken = 1'($urandom_range(0, 1));
            rTgt   = targetPool[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 0) begin
                rPredTaken  = modelPredTaken(rPc);
                rPredTarget = modelPredTarget(rPc);
            end else begin
                rPredTaken  = 1'($urandom_range(0, 1));
                rPredTarget = targetPool[$urandom_range(0, 3)];
            end
            rst_n = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            applyStimulus(rIf, 1'($urandom_range(0, 3) != 0), rPc, rTaken, rTgt, rPredTaken, rPredTarget);
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameters:
- XLEN, 32, address width
- ENTRIES, 16, table depth (power of two, >= 2)
- IDX_W, log2(ENTRIES), index width

REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- if_pc  input  XLEN  PC being fetched (IF lookup)
- pred_taken  output  1  predict taken for if_pc
- pred_target  output  XLEN  predicted target; 0 when pred_taken=0
- upd_valid  input  1  EX resolved a branch/jump this cycle
- upd_pc  input  XLEN  PC of the resolved instruction
- upd_taken  input  1  actual direction
- upd_target  input  XLEN  actual target when taken
- upd_pred_taken  input  1  prediction carried down the pipe with the instruction
- upd_pred_target  input  XLEN  predicted target carried down the pipe
- mispredict  output  1  flush request to IF/ID and ID/EX
- redirect_pc  output  XLEN  correct next PC when mispredict=1; 0 otherwise
- stat_branches  output  32  resolved-branch count
- stat_mispredicts  output  32  mispredict count

Function
REQ-003 Each entry SHALL hold valid (1b), tag (XLEN-IDX_W-2 bits), target (XLEN), ctr (2b).
REQ-004 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
REQ-005 Lookup SHALL be combinational: hit = valid && tag match; pred_taken = hit && ctr[1]; pred_target = entry target when pred_taken, else 0.
REQ-006 mispredict SHALL be combinational: upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
REQ-007 redirect_pc SHALL be upd_target if upd_taken, else upd_pc+4 (mod 2^XLEN); only meaningful while mispredict=1, 0 otherwise.
REQ-008 On upd_valid with hit: ctr SHALL saturate-increment toward 3 if taken, saturate-decrement toward 0 if not taken; target SHALL be overwritten with upd_target if taken.
REQ-009 On upd_valid with miss and upd_taken=1: entry SHALL be allocated (valid=1, new tag, target=upd_target, ctr=2), replacing any aliasing entry.
REQ-010 On upd_valid with miss and upd_taken=0: table SHALL be unchanged.
REQ-011 Table writes SHALL take effect at the next rising edge: a lookup and an update to the same index in the same cycle SHALL return the pre-update contents; a lookup in the following cycle SHALL see the new contents.
REQ-012 At most one update per cycle; upd_* SHALL be ignored when upd_valid=0.
REQ-013 stat_branches SHALL increment by 1 per cycle with upd_valid=1; stat_mispredicts SHALL increment by 1 per cycle with mispredict=1; both SHALL saturate at 32'hFFFFFFFF, not wrap.

Reset
REQ-014 While rst_n=0 at a rising edge, all valid bits SHALL clear, all ctr SHALL become 2'b01, and both stat counters SHALL become 0; tags and targets are don't-care.
REQ-015 Reset SHALL take priority over a simultaneous update; after reset pred_taken=0, pred_target=0 for every if_pc.
REQ-016 mispredict and redirect_pc are combinational and follow REQ-006/REQ-007 even during reset; the pipeline gates them with its own reset.

Verification
REQ-017 Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0; stat_branches=0, stat_mispredicts=0.
REQ-018 Update pc=0x100, taken, target=0x200, pred_taken=0 -> mispredict=1, redirect_pc=0x200 that cycle; next cycle lookup 0x100 -> pred_taken=1, pred_target=0x200 (ctr=2).
REQ-019 Same branch resolved not-taken twice after REQ-018 -> ctr 2->1->0; lookup 0x100 -> pred_taken=0; the first of these updates (pred_taken=1) gives mispredict=1, redirect_pc=0x104.
REQ-020 Taken branch at 0x100 allocated, then taken branch at 0x100+4*ENTRIES (same index, other tag) -> entry replaced; lookup 0x100 -> pred_taken=0.
REQ-021 Same-cycle lookup and first allocating update at 0x140 -> pred_taken=0 that cycle, 1 next cycle.
REQ-022 Taken with correct direction but upd_pred_target=0x300 vs upd_target=0x200 -> mispredict=1, redirect_pc=0x200; stat counters preloaded near 32'hFFFFFFFF saturate and do not wrap.
